// File: rtl/mux_scan_seq_pkg.sv
// mux_scan_seq_pkg: shared types and widths for the mux scan sequencer.
//   state_t  - sequencer FSM states (IDLE, SCAN, DONE)
//   DATA_W   - width of the serialized word / mux data inputs
//   SEL_W    - width of the mux select
//   SEL_MAX  - last select value of a scan pass
package mux_scan_seq_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] SEL_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_seq_if.sv
// mux_scan_seq_if: request/response bundle of the mux scan sequencer.
//   start, data_in, stop : requester -> sequencer
//   D, sel, EN           : sequencer -> downstream 8-to-1 mux
//   busy, done           : sequencer status
// master: requester side; slave: the sequencer itself.
interface mux_scan_seq_if;
    import mux_scan_seq_pkg::*;

    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              stop;
    logic [DATA_W-1:0] D;
    logic [SEL_W-1:0]  sel;
    logic              EN;
    logic              busy;
    logic              done;

    modport master (
        output start, data_in, stop,
        input  D, sel, EN, busy, done
    );

    modport slave (
        input  start, data_in, stop,
        output D, sel, EN, busy, done
    );

endinterface

// File: rtl/mux_step_timer.sv
// mux_step_timer: counts cycles of 'run' and pulses 'tick' on the last cycle
// of every STEP_CYCLES-cycle hold period.
//   clk, rst (sync, active high), clear (restart count), run (count enable)
//   tick : combinational, high in the final cycle of a hold period
module mux_step_timer #(
    parameter int STEP_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(STEP_CYCLES - 1);

    logic [7:0] cnt;

    // clear takes precedence so a restart never coincides with a step
    assign tick = run && !clear && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= 8'd0;
        end else if (run) begin
            cnt <= tick ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: captures a word on start and walks an 8-to-1 mux select
// through 0..7, holding each value STEP_CYCLES cycles with EN high.
//   clk  : clock; rst : synchronous active-high reset
//   bus  : mux_scan_seq_if.slave (start/data_in/stop in; D/sel/EN/busy/done out)
// Build option: define MUX_SCAN_LOOP_EN to wrap sel 7->0 and keep scanning,
// pulsing done with every wrapped sel=0; only stop or rst end the scan.
// All outputs are registered from next-state values.
module mux_scan_seq
    import mux_scan_seq_pkg::*;
#(
    parameter int STEP_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_seq_if.slave   bus
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] d_q, d_nxt;
    logic [SEL_W-1:0]  sel_q, sel_nxt;
    logic              en_q, en_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              clr, tick;

    mux_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (clr),
        .run   (state == SCAN),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            d_q    <= '0;
            sel_q  <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            d_q    <= d_nxt;
            sel_q  <= sel_nxt;
            en_q   <= en_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        d_nxt     = d_q;
        sel_nxt   = sel_q;
        en_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                sel_nxt = '0;
                if (bus.start) begin
                    state_nxt = SCAN;
                    d_nxt     = bus.data_in;
                    en_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    clr       = 1'b1;
                end
            end
            SCAN: begin
                en_nxt   = 1'b1;
                busy_nxt = 1'b1;
                // stop beats a coinciding final-step completion
                if (bus.stop) begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                    en_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                    clr       = 1'b1;
                end else if (tick) begin
                    if (sel_q == SEL_MAX) begin
`ifdef MUX_SCAN_LOOP_EN
                        sel_nxt  = '0;
                        done_nxt = 1'b1;
`else
                        state_nxt = DONE;
                        sel_nxt   = '0;
                        en_nxt    = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
`endif
                    end else begin
                        sel_nxt = sel_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
            end
        endcase
    end

    assign bus.D    = d_q;
    assign bus.sel  = sel_q;
    assign bus.EN   = en_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// tb_mux_scan_seq: scoreboard bench for mux_scan_seq.
// Two instances: dut_a with STEP_CYCLES=1, dut_b with STEP_CYCLES=3.
// Each driven cycle pushes the expected {D,sel,EN,busy,done} seen after the
// following rising edge; a monitor pops and compares just after each edge.
// Follows MUX_SCAN_LOOP_EN when defined.
module tb_mux_scan_seq;

    logic clk = 1'b0;
    logic ra, rb;
    always #5 clk = ~clk;

    mux_scan_seq_if ia ();
    mux_scan_seq_if ib ();

    mux_scan_seq #(.STEP_CYCLES(1)) dut_a (.clk(clk), .rst(ra), .bus(ia.slave));
    mux_scan_seq #(.STEP_CYCLES(3)) dut_b (.clk(clk), .rst(rb), .bus(ib.slave));

    logic [13:0] qa[$];
    logic [13:0] qb[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [13:0] ex(input logic [7:0] d, input logic [2:0] s,
                                       input logic en, input logic bz, input logic dn);
        return {d, s, en, bz, dn};
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got D=%h sel=%0d EN=%b busy=%b done=%b, want D=%h sel=%0d EN=%b busy=%b done=%b",
                     tag, obs[13:6], obs[5:3], obs[2], obs[1], obs[0],
                     exp[13:6], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (qa.size() > 0) chk("dut_a", {ia.D, ia.sel, ia.EN, ia.busy, ia.done}, qa.pop_front());
        if (qb.size() > 0) chk("dut_b", {ib.D, ib.sel, ib.EN, ib.busy, ib.done}, qb.pop_front());
    end

    task automatic cyc_a(input logic r, input logic st, input logic sp,
                         input logic [7:0] di, input logic [13:0] e);
        @(negedge clk);
        ra = r; ia.start = st; ia.stop = sp; ia.data_in = di;
        qa.push_back(e);
    endtask

    task automatic cyc_b(input logic r, input logic st, input logic sp,
                         input logic [7:0] di, input logic [13:0] e);
        @(negedge clk);
        rb = r; ib.start = st; ib.stop = sp; ib.data_in = di;
        qb.push_back(e);
    endtask

    function automatic logic [7:0] rnd();
        return 8'($urandom);
    endfunction

`ifndef MUX_SCAN_LOOP_EN
    // One-shot scan on dut_a. stop_at/rst_at/mid_at name the sel value
    // during which stop, rst or a stray start (data 3C) is driven; -1 = never.
    task automatic scan_a(input logic [7:0] di, input int stop_at, input int rst_at,
                          input int mid_at, input logic st_sp);
        cyc_a(0, 1, st_sp, di, ex(di, 0, 1, 1, 0));
        for (int s = 1; s <= 8; s++) begin
            if (s - 1 == stop_at) begin
                cyc_a(0, 0, 1, rnd(), ex(di, 0, 0, 0, 0));
                cyc_a(0, 0, 0, rnd(), ex(di, 0, 0, 0, 0));
                return;
            end
            if (s - 1 == rst_at) begin
                cyc_a(1, 0, 0, rnd(), ex(8'h00, 0, 0, 0, 0));
                cyc_a(0, 0, 0, rnd(), ex(8'h00, 0, 0, 0, 0));
                return;
            end
            if (s < 8)
                cyc_a(0, (s - 1 == mid_at), 0, (s - 1 == mid_at) ? 8'h3C : rnd(),
                      ex(di, 3'(s), 1, 1, 0));
            else
                cyc_a(0, 0, 0, rnd(), ex(di, 0, 0, 0, 1));
        end
        cyc_a(0, 0, 0, rnd(), ex(di, 0, 0, 0, 0));
    endtask
`endif

    initial begin
        ra = 1'b1; rb = 1'b1;
        ia.start = 0; ia.stop = 0; ia.data_in = 8'h00;
        ib.start = 0; ib.stop = 0; ib.data_in = 8'h00;

        // reset and idle state, with start/stop pressure during reset
        cyc_a(1, 1, 1, 8'hFF, ex(8'h00, 0, 0, 0, 0));
        cyc_b(1, 0, 0, 8'h00, ex(8'h00, 0, 0, 0, 0));
        cyc_a(0, 0, 0, 8'h11, ex(8'h00, 0, 0, 0, 0));
        ib.start = 0;
        rb = 0;

`ifndef MUX_SCAN_LOOP_EN
        scan_a(8'hA5, -1, -1, -1, 0);   // plain scan
        scan_a(8'hC3, -1, -1,  3, 0);   // stray start mid-scan
        scan_a(8'h5A,  4, -1, -1, 0);   // stop at sel=4
        scan_a(8'h96,  7, -1, -1, 1);   // start+stop in IDLE, stop on final step
        scan_a(8'h77, -1,  5, -1, 0);   // rst at sel=5
        scan_a(8'hE1, -1, -1, -1, 0);   // normal after reset

        // 3-cycle hold: 24 EN cycles, done on cycle 25
        cyc_b(0, 1, 0, 8'h5A, ex(8'h5A, 0, 1, 1, 0));
        for (int c = 2; c <= 24; c++)
            cyc_b(0, (c == 10), 0, rnd(), ex(8'h5A, 3'((c - 1) / 3), 1, 1, 0));
        cyc_b(0, 0, 0, rnd(), ex(8'h5A, 0, 0, 0, 1));
        cyc_b(0, 0, 0, rnd(), ex(8'h5A, 0, 0, 0, 0));
`else
        // continuous scan: two wraps, done with each wrapped sel=0, then stop
        cyc_a(0, 1, 0, 8'hA5, ex(8'hA5, 0, 1, 1, 0));
        for (int w = 0; w < 2; w++) begin
            for (int s = 1; s <= 7; s++)
                cyc_a(0, 0, 0, rnd(), ex(8'hA5, 3'(s), 1, 1, 0));
            cyc_a(0, 0, 0, rnd(), ex(8'hA5, 0, 1, 1, 1));
        end
        cyc_a(0, 0, 0, rnd(), ex(8'hA5, 1, 1, 1, 0));
        cyc_a(0, 0, 1, rnd(), ex(8'hA5, 0, 0, 0, 0));
        cyc_a(0, 0, 0, rnd(), ex(8'hA5, 0, 0, 0, 0));

        cyc_b(0, 1, 0, 8'h5A, ex(8'h5A, 0, 1, 1, 0));
        for (int c = 2; c <= 24; c++)
            cyc_b(0, 0, 0, rnd(), ex(8'h5A, 3'((c - 1) / 3), 1, 1, 0));
        cyc_b(0, 0, 0, rnd(), ex(8'h5A, 0, 1, 1, 1));
        cyc_b(0, 0, 0, rnd(), ex(8'h5A, 0, 1, 1, 0));
        cyc_b(0, 0, 1, rnd(), ex(8'h5A, 0, 0, 0, 0));
        cyc_b(0, 0, 0, rnd(), ex(8'h5A, 0, 0, 0, 0));
`endif

        // drain scoreboards, bounded
        for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++)
            @(negedge clk);
        chk("drain", 14'(qa.size() + qb.size()), 14'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_scan_seq.md
MUX_SCAN_SEQ -- requirements
Module: mux_scan_seq

Interface
REQ-001 Parameter: STEP_CYCLES, default 1, clock cycles each sel value is held (legal range 1..255).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  scan request; sampled only in IDLE.
REQ-005 Port: data_in  input  8  word to serialize; captured when start is accepted.
REQ-006 Port: stop  input  1  abort request; sampled in SCAN.
REQ-007 Port: D  output  8  registered word driven into the downstream 8-to-1 mux data inputs.
REQ-008 Port: sel  output  3  registered mux select.
REQ-009 Port: EN  output  1  registered mux enable; high only while a sel value is valid.
REQ-010 Port: busy  output  1  high in SCAN.
REQ-011 Port: done  output  1  one-cycle completion pulse.

Function
REQ-012 FSM states SHALL be IDLE, SCAN and DONE.
REQ-013 IDLE: EN=0, busy=0, done=0, sel=0; D holds its last value.
REQ-014 start=1 in IDLE at edge N SHALL load D<=data_in and enter SCAN, so EN=1, busy=1, sel=0 in the cycle after edge N.
REQ-015 In SCAN each sel value SHALL be held exactly STEP_CYCLES cycles, then sel increments by 1.
REQ-016 After sel=7 completes its hold (loop mode off), the FSM SHALL enter DONE: EN=0, busy=0, done=1 for exactly one cycle, then IDLE.
REQ-017 Total scan duration SHALL be exactly 8*STEP_CYCLES cycles with EN=1, followed by a single done cycle.
REQ-018 start while in SCAN or DONE SHALL be ignored; data_in changes SHALL NOT affect D outside the accept edge.
REQ-019 stop=1 in SCAN SHALL return the FSM to IDLE on the next edge with EN=0, sel=0, and no done pulse.
REQ-020 If stop and the final-step completion coincide, stop SHALL win: IDLE, no done.
REQ-021 start and stop together in IDLE: start is accepted; stop is ignored in IDLE.
REQ-022 The step counter SHALL reset to 0 on every sel change, on accept, and on stop.

Reset
REQ-023 rst=1 SHALL force IDLE, D=8'h00, sel=0, EN=0, busy=0, done=0, step counter=0 on the next edge, overriding all other inputs, including mid-scan.

Configuration
REQ-024 Macro MUX_SCAN_LOOP_EN, when defined, SHALL make sel wrap 7->0 and continue scanning instead of entering DONE.
REQ-025 With MUX_SCAN_LOOP_EN, done SHALL pulse for one cycle coincident with the first cycle of each wrapped sel=0, EN stays 1, and only stop or rst exits SCAN.
REQ-026 Without MUX_SCAN_LOOP_EN, behaviour SHALL be one-shot as in REQ-016; the DONE state is reachable only in this mode.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, SCAN, DONE), DATA_W=8 and SEL_W=3.
REQ-028 The hold timing SHALL be a sub-module mux_step_timer (inputs clk, rst, clear, run; output tick after STEP_CYCLES cycles of run).
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-030 STEP_CYCLES=1, start with data_in=8'hA5 -> D=8'hA5, sel 0..7 over 8 consecutive cycles with EN=1, then done=1 for one cycle, then IDLE.
REQ-031 STEP_CYCLES=3, start -> each sel held 3 cycles; 24 EN cycles; done on cycle 25 after accept.
REQ-032 Mid-scan start with data_in=8'h3C -> D unchanged, scan unaffected.
REQ-033 stop asserted at sel=4 -> next cycle EN=0, sel=0, busy=0, no done; stop on the final step -> no done.
REQ-034 rst asserted at sel=5 -> next cycle all outputs at reset values; a new start then works normally.
REQ-035 MUX_SCAN_LOOP_EN defined, STEP_CYCLES=1 -> sel 0..7,0..7 continuous, done pulses with each wrapped sel=0, stop terminates.
